// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage and the data memory responder.
//   req_*  : MEM-stage access request (valid/ready handshake)
//   resp_* : load data / error response toward MEM/WB (valid/ready handshake)
//   stall  : pipeline hold request, high whenever a request cannot be taken
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory for a pipelined core's MEM stage.
// One access at a time: a request is taken in IDLE, waits LATENCY cycles,
// then the response is held until the consumer accepts it.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset (clears memory and aborts access)
//   bus   : data_mem_responder_if.slave (request, response, stall)
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic                  clk,
  input logic                  reset,
  data_mem_responder_if.slave  bus
);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [63:0] resp_rdata_q;
  logic [63:0] mem_q [DEPTH];

  logic            addr_err;
  logic [IDXW-1:0] idx;

  // Index bits only address the array when the error check has passed.
  assign idx      = addr_q[3 +: IDXW];
  assign addr_err = (addr_q[2:0] != 3'd0) || (addr_q[63:3] >= 61'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          write_q <= bus.req_write;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          cnt_q   <= 4'(LATENCY - 1);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == 4'd0) begin
          // Access happens on the edge entering RESP; a reset before this
          // edge therefore drops a pending store entirely.
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= addr_err;
          resp_rdata_q <= (addr_err || write_q) ? 64'd0 : mem_q[idx];
          if (!addr_err && write_q) mem_q[idx] <= wdata_q;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: if (bus.resp_ready) begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.stall      = (state_q != IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset, rst1;
  always #5 clk = ~clk;

  data_mem_responder_if m();
  data_mem_responder_if m1();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .bus(m.slave));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(m1.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold = 0;
  bit mon_en = 0;
  bit done1 = 0;

  typedef struct {
    bit          w;
    logic [63:0] a;
    logic [63:0] d;
    int          acc;
  } req_t;
  req_t q[$];
  logic [63:0] ref_mem [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Response consumer: random backpressure, forced low while hold > 0.
  always @(posedge clk) begin
    #1;
    if (hold > 0) begin
      m.resp_ready = 1'b0;
      hold--;
    end else begin
      m.resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: reference model evaluated in access order when each response appears.
  bit          have_cur = 0;
  bit          expect_idle = 0;
  logic [63:0] cur_rdata;
  logic        cur_err;
  req_t        t;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("stall", m.stall, !m.req_ready);
      if (expect_idle) chk("resp_drop", m.resp_valid, 1'b0);
      expect_idle = 0;
      if (m.resp_valid === 1'b1) begin
        if (!have_cur) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp act=valid exp=none (cyc %0d)", cyc);
            cur_rdata = m.resp_rdata; cur_err = m.resp_err;
          end else begin
            int unsigned ix;
            t = q.pop_front();
            ix = int'(t.a >> 3);
            cur_err = (t.a[2:0] != 3'd0) || ((t.a >> 3) >= 64'(DEPTH));
            cur_rdata = (cur_err || t.w) ? 64'd0 : ref_mem[ix];
            if (!cur_err && t.w) ref_mem[ix] = t.d;
            chk("latency", 64'(cyc), 64'(t.acc + LAT));
          end
          have_cur = 1;
        end
        chk("rdata", m.resp_rdata, cur_rdata);
        chk("err", m.resp_err, cur_err);
        if (m.resp_ready) begin
          have_cur = 0;
          expect_idle = 1;
        end
      end
    end
  end

  // Waits for IDLE, pushing junk requests meanwhile (must be ignored).
  task automatic issue(input bit w, input logic [63:0] a, input logic [63:0] d, input bit abort);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (m.req_ready) begin
        m.req_valid = 1'b1; m.req_write = w; m.req_addr = a; m.req_wdata = d;
        q.push_back('{w: w, a: a, d: d, acc: cyc + 1});
        done = 1;
      end else begin
        m.req_valid = 1'($urandom_range(0, 1));
        m.req_write = 1'($urandom_range(0, 1));
        m.req_addr  = {$urandom, $urandom} & 64'h1F8;
        m.req_wdata = {$urandom, $urandom};
        n++;
        if (n > 200) begin
          checks++; errors++;
          $display("FAIL issue_timeout act=busy exp=ready (cyc %0d)", cyc);
          done = 1;
        end
      end
    end
    if (abort) begin
      @(negedge clk);
      reset = 1'b1;
      q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      @(negedge clk);
      reset = 1'b0;
      m.req_valid = 1'b0;
      chk("ready_after_abort", m.req_ready, 1'b1);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    int sel = $urandom_range(0, 9);
    logic [63:0] a;
    if (sel < 4)      a = 64'($urandom_range(0, 7)) << 3;
    else if (sel < 7) a = 64'($urandom_range(0, DEPTH - 1)) << 3;
    else if (sel == 7) a = (64'($urandom_range(0, DEPTH - 1)) << 3) + 64'($urandom_range(1, 7));
    else if (sel == 8) a = {$urandom, $urandom} | 64'h1000;
    else              a = 64'($urandom_range(DEPTH - 1, DEPTH)) << 3;
    return a;
  endfunction

  // LATENCY=1 instance: continuous requests, always-ready consumer.
  initial begin
    int nacc = 0;
    rst1 = 1'b1;
    m1.req_valid = 1'b1; m1.req_write = 1'b0; m1.req_addr = '0; m1.req_wdata = '0;
    m1.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      chk("l1_ready", m1.req_ready, 1'((i % 3) == 0));
      chk("l1_stall", m1.stall, 1'((i % 3) != 0));
      chk("l1_valid", m1.resp_valid, 1'((i % 3) == 2));
      if (m1.resp_valid) chk("l1_rdata", m1.resp_rdata, 64'd0);
      if (m1.req_ready) nacc++;
    end
    chk("l1_accepts", 64'(nacc), 64'd14);
    done1 = 1;
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    reset = 1'b1;
    m.req_valid = 1'b1; m.req_write = 1'b1; m.req_addr = 64'h10; m.req_wdata = '1;
    m.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", m.resp_valid, 1'b0);
    chk("rst_rdata", m.resp_rdata, 64'd0);
    chk("rst_err", m.resp_err, 1'b0);
    reset = 1'b0;
    m.req_valid = 1'b0;
    chk("rst_ready", m.req_ready, 1'b1);
    chk("rst_stall", m.stall, 1'b0);
    mon_en = 1;

    issue(1, 64'h10, 64'hDEADBEEFCAFEF00D, 0);
    issue(0, 64'h10, 64'h0, 0);
    hold = 5;
    issue(0, 64'h08, 64'h0, 0);
    issue(1, 64'h13, 64'h1111, 0);
    issue(0, 64'h10, 64'h0, 0);
    issue(0, 64'h200, 64'h0, 0);
    issue(1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    issue(0, 64'h0, 64'h0, 0);
    issue(0, 64'h1F8, 64'h0, 0);
    issue(0, 64'h10, 64'h0, 0);
    issue(1, 64'h18, 64'h5A, 1);
    issue(0, 64'h18, 64'h0, 0);
    issue(0, 64'h10, 64'h0, 0);

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 5) == 0) hold = $urandom_range(1, 6);
      issue(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
            ($urandom_range(0, 24) == 0));
    end

    begin
      int n = 0;
      do begin
        @(negedge clk);
        m.req_valid = 1'b0;
        n++;
      end while ((q.size() != 0 || have_cur || m.resp_valid) && n < 100);
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL drain_timeout act=%0d exp=0 (pending)", q.size());
      end
    end

    begin
      int n = 0;
      while (!done1 && n < 200) begin @(negedge clk); n++; end
      if (!done1) begin
        checks++; errors++;
        $display("FAIL l1_timeout act=0 exp=1 (done)");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
